// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: the write-to-fetch redirect, the decode-side output with its
// stall, and the instruction-memory read port.
interface fetch_if;
    logic [31:0] write_pc;
    logic        write_has_flushed;
    logic        hold;
    logic        mem_address_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_data_valid;
    logic        out_is_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] next_pc;

    // Fetch unit side.
    modport master (
        input  write_pc,
        input  write_has_flushed,
        input  hold,
        input  mem_data,
        input  mem_data_valid,
        output mem_address_enable,
        output mem_address,
        output out_is_valid,
        output out_instruction,
        output out_pc,
        output next_pc
    );

    // Environment side: write stage, decode and instruction memory.
    modport slave (
        output write_pc,
        output write_has_flushed,
        output hold,
        output mem_data,
        output mem_data_valid,
        input  mem_address_enable,
        input  mem_address,
        input  out_is_valid,
        input  out_instruction,
        input  out_pc,
        input  next_pc
    );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: issues sequential memory reads from fetch_pc, presents one
// instruction per cycle to decode, and parks a word in a one-entry skid buffer when
// decode stalls so that nothing already returned from memory is lost.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input logic    clock,
    input logic    reset,
    fetch_if.master bus
);

    localparam logic [31:0] Step = 32'(PC_STEP);

    typedef enum logic [1:0] {
        StFlush,
        StIssue,
        StStalled
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic accept;
    logic consume;

    // Reset is gated in so no request escapes while reset is still being applied.
    assign bus.mem_address_enable = (state_q == StIssue) && !reset;
    assign bus.mem_address        = fetch_pc_q;
    assign bus.out_is_valid       = out_valid_q;
    assign bus.out_instruction    = out_instr_q;
    assign bus.out_pc             = out_pc_q;
    assign bus.next_pc            = out_pc_q + Step;

    assign accept  = bus.mem_address_enable && bus.mem_data_valid;
    assign consume = out_valid_q && !bus.hold;

    // Next-state: output/skid movement, fetch PC advance, FSM, with flush overriding all.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // Decode takes the current word; refill from the skid if it holds one.
        if (consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // A returning word may only bypass into the output if the skid is empty,
        // otherwise it would overtake the older skid entry.
        if (accept) begin
            fetch_pc_d = fetch_pc_q + Step;
            if ((!out_valid_q || consume) && !skid_valid_q) begin
                out_valid_d = 1'b1;
                out_instr_d = bus.mem_data;
                out_pc_d    = fetch_pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.mem_data;
                skid_pc_d    = fetch_pc_q;
            end
        end

        unique case (state_q)
            StFlush:   state_d = StIssue;
            StIssue:   if (skid_valid_d) state_d = StStalled;
            StStalled: if (consume) state_d = StIssue;
            default:   state_d = StFlush;
        endcase

        if (bus.write_has_flushed) begin
            state_d      = StFlush;
            fetch_pc_d   = bus.write_pc;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFlush;
            fetch_pc_q   <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage at the head of the pipeline.
- Consumes the committed PC and flush indication from the write stage; this is the fetch side of the write-to-fetch link.
- Issues instruction-memory reads and presents one instruction per cycle, with its PC, to decode.
- Produces next_pc, which the write stage uses as its default PC update.
- Holds a one-entry skid buffer so a downstream stall never drops a returning word.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
write_pc  in  32  PC committed by the write stage.
write_has_flushed  in  1  redirect: refetch from write_pc.
hold  in  1  decode stall; output must stay stable while out_is_valid.
mem_address_enable  out  1  read request, held until accepted.
mem_address  out  32  read address, stable while enable is high.
mem_data  in  32  read data.
mem_data_valid  in  1  read data valid; may assert in the same cycle as enable.
out_is_valid  out  1  out_instruction/out_pc valid.
out_instruction  out  32  fetched instruction word.
out_pc  out  32  address of out_instruction.
next_pc  out  32  out_pc + PC_STEP, modulo 2^32.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- State registers: fetch_pc; state in {FLUSH, ISSUE, STALLED}; output register (valid, instruction, pc); skid register (valid, instruction, pc).
- Reset (priority 1):
  - fetch_pc <= RESET_PC; state <= FLUSH.
  - out_is_valid = 0; skid cleared; out_instruction = 0; out_pc = 0.
  - mem_address_enable = 0 while reset is asserted and in the first cycle after it.
- Combinational outputs:
  - mem_address_enable = (state == ISSUE).
  - mem_address = fetch_pc.
  - next_pc = out_pc + PC_STEP.
- Accept: a clock edge with mem_address_enable && mem_data_valid.
- Consume: a clock edge with out_is_valid && !hold.
- Flush (priority 2): write_has_flushed sampled high at an edge:
  - fetch_pc <= write_pc; state <= FLUSH.
  - out_is_valid <= 0; skid cleared.
  - Any data accepted on that edge is discarded.
- FLUSH state: enable low for exactly one cycle, then -> ISSUE.
  - Flush-to-first-valid latency with zero-wait memory is 3 cycles.
- ISSUE, on accept:
  - fetch_pc <= fetch_pc + PC_STEP (wraps 32'hFFFF_FFFC -> 0).
  - The word goes to the output register if it is empty or being consumed on the same edge and the skid is empty.
  - Otherwise it goes to the skid.
  - If the skid is then full, state <= STALLED.
- ISSUE without accept: enable and address stay constant; any number of memory wait states is allowed.
- Consume with skid valid: skid moves into the output register; skid cleared.
- STALLED:
  - Enable low.
  - On consume: skid -> output, state <= ISSUE.
- hold while out_is_valid = 0 has no effect.
- Ordering: instructions leave in fetch order, with no duplicates and no drops, absent a flush.
- Throughput: one instruction per cycle with zero-wait memory and hold low.

Test Plan:
- Reset, then zero-wait memory returning 32'hA000_0000+address, hold=0:
  - enable=0 in the first cycle after reset.
  - out_pc sequence 0, 4, 8, 12 on consecutive cycles.
  - next_pc = out_pc+4.
- Memory with 2 wait states per read: address held stable through the wait; one out_is_valid pulse per 3 cycles; PCs contiguous.
- hold=1 for 4 cycles while streaming:
  - out stays at pc 8.
  - pc 12 captured in the skid; enable drops (STALLED).
  - After release, out shows 8, then 12, then 16, with no gap or duplicate.
- write_has_flushed=1 with write_pc=32'h0000_0100, coinciding with a mem_data_valid:
  - That word is discarded; out_is_valid=0.
  - One enable-low cycle, then address 0x100.
  - out_pc=0x100 three cycles after the flush.
- RESET_PC=32'hFFFF_FFF8, streaming: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; next_pc at FFFF_FFFC equals 0.
- reset asserted while STALLED with the skid full: next cycle out_is_valid=0, enable=0, fetch_pc=RESET_PC; the next valid output has out_pc=RESET_PC.
